// File: rtl/itcm_load_ahb_master_pkg.sv
// Shared bus widths, ITCM base address, AHB-Lite encodings and FSM state type
// for the ITCM auto-load AHB master.
package itcm_load_ahb_master_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    // Base of the ITCM image; HADDR parks here out of reset.
    localparam logic [ADDR_WIDTH-1:0] ITCM_START_ADDR = ADDR_WIDTH'(32'h0000_0000);

    // AHB-Lite transfer type, size and burst encodings.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Load sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ACTIVE     = 2'b01,
        ST_ERR_CANCEL = 2'b10
    } load_state_t;

endpackage : itcm_load_ahb_master_pkg

// File: rtl/itcm_load_ahb_master.sv
// AHB-Lite read master that streams the ITCM image in as SINGLE word reads,
// one address per cycle, with at most one data phase outstanding. Bus errors
// return a zero word, raise a sticky flag and the cancelled address is retried.
module itcm_load_ahb_master
    import itcm_load_ahb_master_pkg::*;
#(
    parameter logic [3:0]  HPROT_VAL = 4'b0010,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  itcm_auto_load,
    input  logic [ADDR_WIDTH-1:0] itcm_auto_load_addr,
    output logic                  IAHB_ready,
    output logic [DATA_WIDTH-1:0] IAHB_read_data,
    output logic                  IAHB_read_data_valid,

    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HWRITE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA,

    output logic                  load_error,
    output logic                  load_done,
    output logic [CNT_W-1:0]      load_beat_cnt
);

    load_state_t           r_state;
    logic                  r_dphase;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_valid;
    logic                  r_error;
    logic                  r_done;
    logic [CNT_W-1:0]      r_beat_cnt;

    logic                  w_addr_req;
    logic                  w_accept;
    logic                  w_beat_end;
    logic                  w_err_first;
    logic                  w_cnt_sat;

    // Address phase request: suppressed while an error response is on the bus
    // so the pipelined address is cancelled rather than accepted.
    assign w_addr_req  = (r_state == ST_ACTIVE) && itcm_auto_load && !(r_dphase && HRESP);
    assign w_accept    = w_addr_req && HREADY;
    assign w_beat_end  = r_dphase && HREADY;
    assign w_err_first = r_dphase && HRESP && !HREADY;
    assign w_cnt_sat   = &r_beat_cnt;

    // Bus outputs: address phase driven straight from the request, held otherwise.
    assign HTRANS     = w_addr_req ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR      = w_addr_req ? itcm_auto_load_addr : r_haddr;
    assign HSIZE      = HSIZE_WORD;
    assign HBURST     = HBURST_SINGLE;
    assign HPROT      = HPROT_VAL;
    assign HWRITE     = 1'b0;
    assign HWDATA     = '0;
    assign IAHB_ready = w_accept;

    assign IAHB_read_data       = r_rdata;
    assign IAHB_read_data_valid = r_valid;
    assign load_error           = r_error;
    assign load_done            = r_done;
    assign load_beat_cnt        = r_beat_cnt;

    // Load sequencer: state, completion pulse and beat counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_beat_end && !w_cnt_sat) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (itcm_auto_load) begin
                        r_state    <= ST_ACTIVE;
                        r_beat_cnt <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_err_first) begin
                        r_state <= ST_ERR_CANCEL;
                    end else if (!itcm_auto_load && !r_dphase) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                ST_ERR_CANCEL: begin
                    if (HREADY) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Data phase tracking, last driven address and returned word capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dphase <= 1'b0;
            r_haddr  <= ITCM_START_ADDR;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_valid <= w_beat_end;
            if (w_accept) begin
                r_dphase <= 1'b1;
            end else if (HREADY) begin
                r_dphase <= 1'b0;
            end
            if (w_addr_req) begin
                r_haddr <= itcm_auto_load_addr;
            end
            if (w_beat_end) begin
                r_rdata <= HRESP ? '0 : HRDATA;
            end
            if (r_dphase && HRESP) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule : itcm_load_ahb_master

// File: tb/tb_itcm_load_ahb_master.sv
// Directed bench for the ITCM auto-load AHB master: per-cycle stimulus rows
// carry hand-derived expected bus and load-interface values.
module tb_itcm_load_ahb_master;
    import itcm_load_ahb_master_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        itcm_auto_load;
    logic [31:0] itcm_auto_load_addr;
    logic        IAHB_ready;
    logic [31:0] IAHB_read_data;
    logic        IAHB_read_data_valid;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        load_error;
    logic        load_done;
    logic [15:0] load_beat_cnt;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic        H   = 1'b1;
    localparam logic        L   = 1'b0;
    localparam logic [1:0]  TI  = 2'b00;
    localparam logic [1:0]  TN  = 2'b10;
    localparam logic [31:0] A0  = 32'h0000_0000;
    localparam logic [31:0] A4  = 32'h0000_0004;
    localparam logic [31:0] A8  = 32'h0000_0008;
    localparam logic [31:0] AC  = 32'h0000_000C;
    localparam logic [31:0] A10 = 32'h0000_0010;
    localparam logic [31:0] D0  = 32'hD000_0000;
    localparam logic [31:0] D4  = 32'hD000_0004;
    localparam logic [31:0] D8  = 32'hD000_0008;
    localparam logic [31:0] DC  = 32'hD000_000C;
    localparam logic [31:0] JK  = 32'hBAD0_BAD0;
    localparam logic [31:0] Z   = 32'h0000_0000;

    always #5 clk = ~clk;

    itcm_load_ahb_master #(
        .HPROT_VAL (4'b0010),
        .CNT_W     (16)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .itcm_auto_load       (itcm_auto_load),
        .itcm_auto_load_addr  (itcm_auto_load_addr),
        .IAHB_ready           (IAHB_ready),
        .IAHB_read_data       (IAHB_read_data),
        .IAHB_read_data_valid (IAHB_read_data_valid),
        .HADDR                (HADDR),
        .HTRANS               (HTRANS),
        .HSIZE                (HSIZE),
        .HBURST               (HBURST),
        .HPROT                (HPROT),
        .HWRITE               (HWRITE),
        .HWDATA               (HWDATA),
        .HREADY               (HREADY),
        .HRESP                (HRESP),
        .HRDATA               (HRDATA),
        .load_error           (load_error),
        .load_done            (load_done),
        .load_beat_cnt        (load_beat_cnt)
    );

    typedef struct {
        logic        rs;
        logic        al;
        logic [31:0] ad;
        logic        rd;
        logic        rp;
        logic [31:0] dt;
        logic [1:0]  et;
        logic [31:0] ea;
        logic        er;
        logic        ev;
        logic [31:0] ed;
        logic        edn;
        logic        eer;
        logic [15:0] ec;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic al, input logic [31:0] ad,
                                input logic rd, input logic rp, input logic [31:0] dt,
                                input logic [1:0] et, input logic [31:0] ea,
                                input logic er, input logic ev, input logic [31:0] ed,
                                input logic edn, input logic eer, input logic [15:0] ec);
        vec_t v;
        v.rs = rs; v.al = al; v.ad = ad; v.rd = rd; v.rp = rp; v.dt = dt;
        v.et = et; v.ea = ea; v.er = er; v.ev = ev; v.ed = ed;
        v.edn = edn; v.eer = eer; v.ec = ec;
        return v;
    endfunction

    // Drive one cycle of inputs on the falling edge and let outputs settle.
    task automatic apply(input vec_t r);
        @(negedge clk);
        rstn                = r.rs;
        itcm_auto_load      = r.al;
        itcm_auto_load_addr = r.ad;
        HREADY              = r.rd;
        HRESP               = r.rp;
        HRDATA              = r.dt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; itcm_auto_load = 1'b0; itcm_auto_load_addr = A0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = JK;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_total++;
        if (HTRANS !== TI || HADDR !== A0 || IAHB_ready !== 1'b0) begin
            $display("FAIL reset_bus got htrans=%h haddr=%h ready=%b want 0 0 0", HTRANS, HADDR, IAHB_ready);
        end else n_pass++;
        n_total++;
        if (IAHB_read_data_valid !== 1'b0 || IAHB_read_data !== Z) begin
            $display("FAIL reset_data got valid=%b data=%h want 0 0", IAHB_read_data_valid, IAHB_read_data);
        end else n_pass++;
        n_total++;
        if (load_error !== 1'b0 || load_done !== 1'b0 || load_beat_cnt !== 16'd0) begin
            $display("FAIL reset_status got err=%b done=%b cnt=%0d want 0 0 0", load_error, load_done, load_beat_cnt);
        end else n_pass++;
        n_total++;
        if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0010 || HWRITE !== 1'b0 || HWDATA !== Z) begin
            $display("FAIL fixed_ctrl got hsize=%h hburst=%h hprot=%h hwrite=%b hwdata=%h want 2 0 2 0 0",
                     HSIZE, HBURST, HPROT, HWRITE, HWDATA);
        end else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_zero_wait();
        vec_t t[$];
        t.push_back(mk(H,H,A0 ,H,L,JK, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A0 ,H,L,JK, TN,A0,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A4 ,H,L,D0, TN,A4,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A8 ,H,L,D4, TN,A8,H,H,D0,L,L,16'd1));
        t.push_back(mk(H,H,AC ,H,L,D8, TN,AC,H,H,D4,L,L,16'd2));
        t.push_back(mk(H,L,A10,H,L,DC, TI,AC,L,H,D8,L,L,16'd3));
        t.push_back(mk(H,L,A10,H,L,JK, TI,AC,L,H,DC,L,L,16'd4));
        t.push_back(mk(H,L,A10,H,L,JK, TI,AC,L,L,DC,H,L,16'd4));
        t.push_back(mk(H,L,A10,H,L,JK, TI,AC,L,L,DC,L,L,16'd4));
        foreach (t[i]) begin
            apply(t[i]);
            n_total++;
            if ({HTRANS, HADDR, IAHB_ready, IAHB_read_data_valid, IAHB_read_data, load_done, load_error, load_beat_cnt}
                !== {t[i].et, t[i].ea, t[i].er, t[i].ev, t[i].ed, t[i].edn, t[i].eer, t[i].ec}) begin
                $display("FAIL zero_wait cyc%0d got tr=%h a=%h rdy=%b v=%b d=%h dn=%b er=%b c=%0d want tr=%h a=%h rdy=%b v=%b d=%h dn=%b er=%b c=%0d",
                         i, HTRANS, HADDR, IAHB_ready, IAHB_read_data_valid, IAHB_read_data, load_done, load_error, load_beat_cnt,
                         t[i].et, t[i].ea, t[i].er, t[i].ev, t[i].ed, t[i].edn, t[i].eer, t[i].ec);
            end else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        vec_t t[$];
        t.push_back(mk(H,H,A0 ,H,L,JK, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A0 ,H,L,JK, TN,A0,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A4 ,H,L,D0, TN,A4,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A8 ,L,L,JK, TN,A8,L,H,D0,L,L,16'd1));
        t.push_back(mk(H,H,A8 ,L,L,JK, TN,A8,L,L,D0,L,L,16'd1));
        t.push_back(mk(H,H,A8 ,H,L,D4, TN,A8,H,L,D0,L,L,16'd1));
        t.push_back(mk(H,H,AC ,H,L,D8, TN,AC,H,H,D4,L,L,16'd2));
        t.push_back(mk(H,L,A10,H,L,DC, TI,AC,L,H,D8,L,L,16'd3));
        t.push_back(mk(H,L,A10,H,L,JK, TI,AC,L,H,DC,L,L,16'd4));
        t.push_back(mk(H,L,A10,H,L,JK, TI,AC,L,L,DC,H,L,16'd4));
        foreach (t[i]) begin
            apply(t[i]);
            n_total++;
            if ({HTRANS, HADDR, IAHB_ready, IAHB_read_data_valid, IAHB_read_data, load_done, load_error, load_beat_cnt}
                !== {t[i].et, t[i].ea, t[i].er, t[i].ev, t[i].ed, t[i].edn, t[i].eer, t[i].ec}) begin
                $display("FAIL wait_states cyc%0d got tr=%h a=%h rdy=%b v=%b d=%h dn=%b er=%b c=%0d want tr=%h a=%h rdy=%b v=%b d=%h dn=%b er=%b c=%0d",
                         i, HTRANS, HADDR, IAHB_ready, IAHB_read_data_valid, IAHB_read_data, load_done, load_error, load_beat_cnt,
                         t[i].et, t[i].ea, t[i].er, t[i].ev, t[i].ed, t[i].edn, t[i].eer, t[i].ec);
            end else n_pass++;
        end
    endtask

    task automatic test_error();
        vec_t t[$];
        t.push_back(mk(H,H,A0 ,H,L,JK, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A0 ,H,L,JK, TN,A0,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A4 ,H,L,D0, TN,A4,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A8 ,H,L,D4, TN,A8,H,H,D0,L,L,16'd1));
        t.push_back(mk(H,H,AC ,L,H,JK, TI,A8,L,H,D4,L,L,16'd2));
        t.push_back(mk(H,H,AC ,H,H,JK, TI,A8,L,L,D4,L,H,16'd2));
        t.push_back(mk(H,H,AC ,H,L,JK, TN,AC,H,H,Z ,L,H,16'd3));
        t.push_back(mk(H,L,A10,H,L,DC, TI,AC,L,L,Z ,L,H,16'd3));
        t.push_back(mk(H,L,A10,H,L,JK, TI,AC,L,H,DC,L,H,16'd4));
        t.push_back(mk(H,L,A10,H,L,JK, TI,AC,L,L,DC,H,H,16'd4));
        foreach (t[i]) begin
            apply(t[i]);
            n_total++;
            if ({HTRANS, HADDR, IAHB_ready, IAHB_read_data_valid, IAHB_read_data, load_done, load_error, load_beat_cnt}
                !== {t[i].et, t[i].ea, t[i].er, t[i].ev, t[i].ed, t[i].edn, t[i].eer, t[i].ec}) begin
                $display("FAIL bus_error cyc%0d got tr=%h a=%h rdy=%b v=%b d=%h dn=%b er=%b c=%0d want tr=%h a=%h rdy=%b v=%b d=%h dn=%b er=%b c=%0d",
                         i, HTRANS, HADDR, IAHB_ready, IAHB_read_data_valid, IAHB_read_data, load_done, load_error, load_beat_cnt,
                         t[i].et, t[i].ea, t[i].er, t[i].ev, t[i].ed, t[i].edn, t[i].eer, t[i].ec);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid_transfer();
        vec_t t[$];
        t.push_back(mk(H,H,A0 ,H,L,JK, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A0 ,H,L,JK, TN,A0,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A4 ,H,L,D0, TN,A4,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A8 ,L,L,JK, TN,A8,L,H,D0,L,L,16'd1));
        t.push_back(mk(L,H,A8 ,L,L,JK, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(L,H,A8 ,H,L,D4, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,L,A8 ,H,L,D4, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,L,A8 ,H,L,D4, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A0 ,H,L,JK, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,H,A0 ,H,L,JK, TN,A0,H,L,Z ,L,L,16'd0));
        t.push_back(mk(H,L,A4 ,H,L,D0, TI,A0,L,L,Z ,L,L,16'd0));
        t.push_back(mk(H,L,A4 ,H,L,JK, TI,A0,L,H,D0,L,L,16'd1));
        t.push_back(mk(H,L,A4 ,H,L,JK, TI,A0,L,L,D0,H,L,16'd1));
        foreach (t[i]) begin
            apply(t[i]);
            n_total++;
            if ({HTRANS, HADDR, IAHB_ready, IAHB_read_data_valid, IAHB_read_data, load_done, load_error, load_beat_cnt}
                !== {t[i].et, t[i].ea, t[i].er, t[i].ev, t[i].ed, t[i].edn, t[i].eer, t[i].ec}) begin
                $display("FAIL reset_mid cyc%0d got tr=%h a=%h rdy=%b v=%b d=%h dn=%b er=%b c=%0d want tr=%h a=%h rdy=%b v=%b d=%h dn=%b er=%b c=%0d",
                         i, HTRANS, HADDR, IAHB_ready, IAHB_read_data_valid, IAHB_read_data, load_done, load_error, load_beat_cnt,
                         t[i].et, t[i].ea, t[i].er, t[i].ev, t[i].ed, t[i].edn, t[i].eer, t[i].ec);
            end else n_pass++;
        end
    endtask

    task automatic test_zero_size();
        vec_t r;
        r = mk(H,L,A0,H,L,JK, TI,A0,L,L,Z,L,L,16'd0);
        for (int i = 0; i < 100; i++) begin
            apply(r);
            n_total++;
            if (HTRANS !== TI || IAHB_ready !== 1'b0 || IAHB_read_data_valid !== 1'b0 || load_done !== 1'b0) begin
                $display("FAIL zero_size cyc%0d got tr=%h rdy=%b v=%b dn=%b want tr=0 rdy=0 v=0 dn=0",
                         i, HTRANS, IAHB_ready, IAHB_read_data_valid, load_done);
            end else n_pass++;
        end
    endtask

    initial begin
        rstn                = 1'b0;
        itcm_auto_load      = 1'b0;
        itcm_auto_load_addr = A0;
        HREADY              = 1'b1;
        HRESP               = 1'b0;
        HRDATA              = JK;

        test_reset();
        test_zero_wait();
        do_reset();
        test_wait_states();
        do_reset();
        test_error();
        do_reset();
        test_reset_mid_transfer();
        do_reset();
        test_zero_size();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_itcm_load_ahb_master
